btb_update_ctrl: RTL and testbench

BTB_UPDATE_CTRL -- requirements
Module: btb_update_ctrl

---
 rtl/btb_update_ctrl_pkg.sv | 16 +
 rtl/btb_update_ctrl_pred_fifo.sv | 53 +++++
 rtl/btb_update_ctrl.sv | 156 +++++++++++++++
 tb/tb_btb_update_ctrl.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/btb_update_ctrl_pkg.sv
// Shared types for the BTB update controller: the in-flight prediction entry and the FSM state.
package btb_pkg;

  typedef struct packed {
    logic [31:0] pc;
    logic        pred_taken;
    logic        hit;
    logic [31:0] target;
  } pred_entry_t;

  typedef enum logic {
    RUN     = 1'b0,
    RECOVER = 1'b1
  } state_t;

endpackage

// File: rtl/btb_update_ctrl_pred_fifo.sv
// In-order queue of fetch-time predictions awaiting resolution; pointers carry an extra wrap bit.
module btb_pred_fifo
  import btb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        push,
  input  logic        pop,
  input  pred_entry_t din,
  output logic        full,
  output logic        empty,
  output pred_entry_t head
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [AW:0] wr_ptr_r;
  logic [AW:0] rd_ptr_r;
  pred_entry_t mem_r [DEPTH];

  assign empty = (wr_ptr_r == rd_ptr_r);
  assign full  = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
  assign head  = mem_r[rd_ptr_r[AW-1:0]];

  // Pointer update; a clear discards everything in flight, including a same-cycle push.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
    end else if (clr) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
    end else begin
      if (push && !full) begin
        wr_ptr_r <= wr_ptr_r + {{AW{1'b0}}, 1'b1};
      end
      if (pop && !empty) begin
        rd_ptr_r <= rd_ptr_r + {{AW{1'b0}}, 1'b1};
      end
    end
  end

  // Entry storage; contents are only meaningful between the pointers, so no reset.
  always_ff @(posedge clk) begin
    if (push && !full && !clr) begin
      mem_r[wr_ptr_r[AW-1:0]] <= din;
    end
  end

endmodule

// File: rtl/btb_update_ctrl.sv
// Compares resolved branches against queued predictions, trains the BTB and redirects fetch.
// Optional saturating statistics counters are built when BTB_UPDATE_STATS_EN is defined.
module btb_update_ctrl
  import btb_pkg::*;
#(
  parameter int DEPTH          = 4,
  parameter int RECOVER_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_push,
  input  logic [31:0] if_pc,
  input  logic        if_hit,
  input  logic        if_taken,
  input  logic [31:0] if_target,
  output logic        if_ready,
  input  logic        ex_valid,
  input  logic [31:0] ex_pc,
  input  logic        ex_taken,
  input  logic [31:0] ex_target,
  output logic        update,
  output logic [31:0] update_pc,
  output logic [31:0] update_target,
  output logic        mispredicted,
  output logic        flush,
  output logic [31:0] redirect_pc,
`ifdef BTB_UPDATE_STATS_EN
  output logic        err,
  output logic [31:0] stat_branches,
  output logic [31:0] stat_mispredicts
`else
  output logic        err
`endif
);

  logic        full_s;
  logic        empty_s;
  logic        push_s;
  logic        pop_s;
  logic        head_ok_s;
  logic        pred_taken_s;
  logic        hit_s;
  logic        wrong_s;
  pred_entry_t din_s;
  pred_entry_t head_s;
  state_t      state_r;
  logic [2:0]  cnt_r;

  assign if_ready = !full_s && (state_r == RUN);
  assign pop_s    = ex_valid && !empty_s;
  assign push_s   = if_push && if_ready && !wrong_s;
  assign din_s    = '{pc: if_pc, pred_taken: if_hit & if_taken, hit: if_hit, target: if_target};

  btb_pred_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (wrong_s),
    .push  (push_s),
    .pop   (pop_s),
    .din   (din_s),
    .full  (full_s),
    .empty (empty_s),
    .head  (head_s)
  );

  // Resolution check; a missing or mismatched head counts as a not-taken miss.
  always_comb begin
    head_ok_s    = 1'b0;
    pred_taken_s = 1'b0;
    hit_s        = 1'b0;
    wrong_s      = 1'b0;
    if (!empty_s && (ex_pc == head_s.pc)) begin
      head_ok_s    = 1'b1;
      pred_taken_s = head_s.pred_taken;
      hit_s        = head_s.hit;
    end else begin
      head_ok_s    = 1'b0;
      pred_taken_s = 1'b0;
      hit_s        = 1'b0;
    end
    if (ex_valid) begin
      wrong_s = (ex_taken != pred_taken_s) ||
                (ex_taken && pred_taken_s && (ex_target != head_s.target));
    end else begin
      wrong_s = 1'b0;
    end
  end

  // Recovery FSM plus registered update/redirect outputs, one cycle after resolution.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= RUN;
      cnt_r         <= 3'd0;
      update        <= 1'b0;
      update_pc     <= 32'd0;
      update_target <= 32'd0;
      mispredicted  <= 1'b0;
      flush         <= 1'b0;
      redirect_pc   <= 32'd0;
      err           <= 1'b0;
    end else begin
      update       <= ex_valid && (ex_taken || hit_s);
      mispredicted <= wrong_s;
      flush        <= wrong_s;
      if (ex_valid) begin
        update_pc     <= ex_pc;
        update_target <= ex_target;
        if (!head_ok_s) begin
          err <= 1'b1;
        end
      end
      if (wrong_s) begin
        redirect_pc <= ex_taken ? ex_target : (ex_pc + 32'd4);
      end
      case (state_r)
        RUN: begin
          if (wrong_s) begin
            state_r <= RECOVER;
            cnt_r   <= 3'd0;
          end
        end
        RECOVER: begin
          if (wrong_s) begin
            cnt_r <= 3'd0;
          end else if (cnt_r == 3'(RECOVER_CYCLES - 1)) begin
            state_r <= RUN;
          end else begin
            cnt_r <= cnt_r + 3'd1;
          end
        end
        default: begin
          state_r <= RUN;
          cnt_r   <= 3'd0;
        end
      endcase
    end
  end

`ifdef BTB_UPDATE_STATS_EN
  // Saturating counts of resolved branches and of wrong predictions.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_branches    <= 32'd0;
      stat_mispredicts <= 32'd0;
    end else begin
      if (ex_valid && (stat_branches != 32'hFFFF_FFFF)) begin
        stat_branches <= stat_branches + 32'd1;
      end
      if (wrong_s && (stat_mispredicts != 32'hFFFF_FFFF)) begin
        stat_mispredicts <= stat_mispredicts + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_btb_update_ctrl.sv
// Directed self-checking bench for btb_update_ctrl in its default configuration.
module tb_btb_update_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_push;
  logic [31:0] if_pc;
  logic        if_hit;
  logic        if_taken;
  logic [31:0] if_target;
  logic        if_ready;
  logic        ex_valid;
  logic [31:0] ex_pc;
  logic        ex_taken;
  logic [31:0] ex_target;
  logic        update;
  logic [31:0] update_pc;
  logic [31:0] update_target;
  logic        mispredicted;
  logic        flush;
  logic [31:0] redirect_pc;
  logic        err;

  int tests = 0;
  int fails = 0;

  btb_update_ctrl dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .if_push       (if_push),
    .if_pc         (if_pc),
    .if_hit        (if_hit),
    .if_taken      (if_taken),
    .if_target     (if_target),
    .if_ready      (if_ready),
    .ex_valid      (ex_valid),
    .ex_pc         (ex_pc),
    .ex_taken      (ex_taken),
    .ex_target     (ex_target),
    .update        (update),
    .update_pc     (update_pc),
    .update_target (update_target),
    .mispredicted  (mispredicted),
    .flush         (flush),
    .redirect_pc   (redirect_pc),
    .err           (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs at the falling edge.
  task automatic drive(input logic p, input logic [31:0] pc, input logic h, input logic t,
                       input logic [31:0] tg, input logic ev, input logic [31:0] epc,
                       input logic et, input logic [31:0] etg);
    @(negedge clk);
    if_push = p; if_pc = pc; if_hit = h; if_taken = t; if_target = tg;
    ex_valid = ev; ex_pc = epc; ex_taken = et; ex_target = etg;
  endtask

  task automatic idle();
    drive(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0);
  endtask

  task automatic push(input logic [31:0] pc, input logic h, input logic t, input logic [31:0] tg);
    drive(1'b1, pc, h, t, tg, 1'b0, 32'd0, 1'b0, 32'd0);
  endtask

  task automatic resolve(input logic [31:0] epc, input logic et, input logic [31:0] etg);
    drive(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b1, epc, et, etg);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    if_push = 1'b0; if_pc = 32'd0; if_hit = 1'b0; if_taken = 1'b0; if_target = 32'd0;
    ex_valid = 1'b0; ex_pc = 32'd0; ex_taken = 1'b0; ex_target = 32'd0;
    repeat (3) @(negedge clk);
    chk("rst_update", {31'd0, update}, 32'd0);
    chk("rst_mispred", {31'd0, mispredicted}, 32'd0);
    chk("rst_flush", {31'd0, flush}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_update_pc", update_pc, 32'd0);
    chk("rst_update_target", update_target, 32'd0);
    chk("rst_redirect", redirect_pc, 32'd0);
    chk("rst_ready", {31'd0, if_ready}, 32'd1);
    rst_n = 1'b1;

    // Correct taken prediction
    push(32'h100, 1'b1, 1'b1, 32'h200);
    resolve(32'h100, 1'b1, 32'h200);
    idle();
    chk("ok_update", {31'd0, update}, 32'd1);
    chk("ok_mispred", {31'd0, mispredicted}, 32'd0);
    chk("ok_flush", {31'd0, flush}, 32'd0);
    chk("ok_update_pc", update_pc, 32'h100);
    chk("ok_update_target", update_target, 32'h200);
    chk("ok_ready", {31'd0, if_ready}, 32'd1);

    // Direction miss: predicted miss, actually taken
    push(32'h104, 1'b0, 1'b0, 32'h0);
    resolve(32'h104, 1'b1, 32'h300);
    idle();
    chk("dir_update", {31'd0, update}, 32'd1);
    chk("dir_mispred", {31'd0, mispredicted}, 32'd1);
    chk("dir_flush", {31'd0, flush}, 32'd1);
    chk("dir_redirect", redirect_pc, 32'h300);
    chk("dir_ready_c1", {31'd0, if_ready}, 32'd0);
    idle();
    chk("dir_flush_pulse", {31'd0, flush}, 32'd0);
    chk("dir_ready_c2", {31'd0, if_ready}, 32'd0);
    idle();
    chk("dir_ready_c3", {31'd0, if_ready}, 32'd1);

    // Target miss
    push(32'h108, 1'b1, 1'b1, 32'h400);
    resolve(32'h108, 1'b1, 32'h500);
    idle();
    chk("tgt_mispred", {31'd0, mispredicted}, 32'd1);
    chk("tgt_redirect", redirect_pc, 32'h500);
    chk("tgt_update_target", update_target, 32'h500);
    chk("tgt_update", {31'd0, update}, 32'd1);
    idle();
    idle();

    // Predicted taken, actually not taken: fall through to pc + 4
    push(32'h10C, 1'b1, 1'b1, 32'h600);
    resolve(32'h10C, 1'b0, 32'h0);
    idle();
    chk("nt_redirect", redirect_pc, 32'h110);
    chk("nt_update", {31'd0, update}, 32'd1);
    chk("nt_mispred", {31'd0, mispredicted}, 32'd1);
    chk("nt_err", {31'd0, err}, 32'd0);
    idle();
    idle();

    // Fill the queue, then mispredict the head while pushing
    push(32'h200, 1'b1, 1'b1, 32'h1000);
    push(32'h204, 1'b1, 1'b1, 32'h1004);
    push(32'h208, 1'b1, 1'b1, 32'h1008);
    push(32'h20C, 1'b1, 1'b1, 32'h100C);
    idle();
    chk("full_ready", {31'd0, if_ready}, 32'd0);
    drive(1'b1, 32'h2F0, 1'b1, 1'b1, 32'h3000, 1'b1, 32'h200, 1'b0, 32'h0);
    idle();
    chk("full_flush", {31'd0, flush}, 32'd1);
    chk("full_redirect", redirect_pc, 32'h204);
    idle();
    idle();

    // Push concurrent with a flush on a non-full queue is dropped
    push(32'h400, 1'b1, 1'b1, 32'h800);
    drive(1'b1, 32'h404, 1'b1, 1'b1, 32'h808, 1'b1, 32'h400, 1'b1, 32'h900);
    idle();
    chk("drop_flush", {31'd0, flush}, 32'd1);
    chk("drop_redirect", redirect_pc, 32'h900);
    idle();
    idle();
    push(32'h500, 1'b1, 1'b1, 32'hA00);
    push(32'h504, 1'b1, 1'b1, 32'hA04);
    push(32'h508, 1'b1, 1'b1, 32'hA08);
    idle();
    chk("drop_three_ready", {31'd0, if_ready}, 32'd1);
    push(32'h50C, 1'b1, 1'b1, 32'hA0C);
    idle();
    chk("drop_four_ready", {31'd0, if_ready}, 32'd0);

    // Push and pop together while full: push refused
    drive(1'b1, 32'h600, 1'b1, 1'b1, 32'hB00, 1'b1, 32'h500, 1'b1, 32'hA00);
    idle();
    chk("fullpp_flush", {31'd0, flush}, 32'd0);
    chk("fullpp_update_pc", update_pc, 32'h500);
    chk("fullpp_ready", {31'd0, if_ready}, 32'd1);
    resolve(32'h504, 1'b1, 32'hA04);
    resolve(32'h508, 1'b1, 32'hA08);
    resolve(32'h50C, 1'b1, 32'hA0C);
    idle();
    chk("drain_mispred", {31'd0, mispredicted}, 32'd0);
    chk("drain_err", {31'd0, err}, 32'd0);

    // Resolution with an empty queue raises the sticky error
    resolve(32'h600, 1'b0, 32'h0);
    idle();
    chk("err_set", {31'd0, err}, 32'd1);
    chk("err_update", {31'd0, update}, 32'd0);
    chk("err_flush", {31'd0, flush}, 32'd0);
    repeat (3) idle();
    chk("err_hold", {31'd0, err}, 32'd1);

    // Reset in the middle of a recovery
    resolve(32'h700, 1'b1, 32'h780);
    idle();
    chk("rec_flush", {31'd0, flush}, 32'd1);
    chk("rec_ready", {31'd0, if_ready}, 32'd0);
    #1 rst_n = 1'b0;
    #1;
    chk("rec_rst_flush", {31'd0, flush}, 32'd0);
    chk("rec_rst_update", {31'd0, update}, 32'd0);
    chk("rec_rst_redirect", redirect_pc, 32'd0);
    chk("rec_rst_err", {31'd0, err}, 32'd0);
    chk("rec_rst_ready", {31'd0, if_ready}, 32'd1);
    idle();
    rst_n = 1'b1;
    idle();
    chk("post_rst_ready", {31'd0, if_ready}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
